// File: rtl/hazard_pkg.sv
// Shared types for the execute-stage hazard controller.
package hazard_pkg;

  // Forward-select encoding driven onto the EX ALU operand muxes.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Tag destination field is sized for the widest register index the
  // controller supports; narrower indices are zero-extended into it.
  localparam int unsigned TAG_DST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_DST_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } stage_tag_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_DST_W-1:0] dst;
    logic                 reg_write;
  } wb_tag_t;

endpackage

// File: rtl/ex_hazard_controller_fwd_match.sv
// fwd_match: does a used source operand name the destination of a live
// register-writing producer held in a stage tag.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  used,
  input  stage_tag_t            tag,
  output logic                  hit
);

  // Load/ALU distinction is the caller's concern; only the match matters here.
  logic unused_mem_read;
  assign unused_mem_read = tag.mem_read;

  // Producer match: operand is read, producer is real and writes that register.
  always_comb begin
    hit = used && tag.valid && tag.reg_write && (tag.dst == TAG_DST_W'(src));
  end

endmodule

// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller: execute-stage pipeline sequencer. Tracks in-flight
// destination tags (EX, MEM, WB), registers operand-forwarding selects with
// the instruction entering EX, stalls decode one cycle on load-use and
// squashes the decode->EX instruction on branch flush.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush counters.
module ex_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic                  id_src1_used,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd1_sel,
  output logic [1:0]            fwd2_sel,
  output logic                  stall,
  output logic                  ex_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  stage_tag_t ex_q;
  stage_tag_t mem_q;
  wb_tag_t    wb_q;
  fwd_sel_t   fwd1_q;
  fwd_sel_t   fwd2_q;

  logic       hit1_ex;
  logic       hit2_ex;
  logic       hit1_mem;
  logic       hit2_mem;

  fwd_sel_t   fwd1_d;
  fwd_sel_t   fwd2_d;
  logic       load_use;
  logic       issue;
  stage_tag_t id_tag;

  // Producers three or more ahead are covered by regfile write-before-read,
  // so the WB tag is retained for visibility only and feeds no decision.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_m1_ex (
    .src (id_src1), .used(id_src1_used), .tag(ex_q),  .hit(hit1_ex)
  );
  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_m2_ex (
    .src (id_src2), .used(id_src2_used), .tag(ex_q),  .hit(hit2_ex)
  );
  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_m1_mem (
    .src (id_src1), .used(id_src1_used), .tag(mem_q), .hit(hit1_mem)
  );
  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_m2_mem (
    .src (id_src2), .used(id_src2_used), .tag(mem_q), .hit(hit2_mem)
  );

  // Select priority, load-use detection and the tag the decode instruction carries.
  always_comb begin
    fwd1_d = FWD_NONE;
    fwd2_d = FWD_NONE;
    if (hit1_ex)       fwd1_d = FWD_EXMEM;
    else if (hit1_mem) fwd1_d = FWD_MEMWB;
    if (hit2_ex)       fwd2_d = FWD_EXMEM;
    else if (hit2_mem) fwd2_d = FWD_MEMWB;

    load_use = id_valid && ex_q.mem_read && (hit1_ex || hit2_ex);
    stall    = load_use && !flush;
    issue    = id_valid && !flush && !load_use;

    id_tag           = '0;
    id_tag.valid     = 1'b1;
    id_tag.dst       = TAG_DST_W'(id_dst);
    id_tag.reg_write = id_reg_write;
    id_tag.mem_read  = id_mem_read;
  end

  // Tag pipeline advances every cycle; EX takes the decode instruction or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fwd1_q <= FWD_NONE;
      fwd2_q <= FWD_NONE;
    end else begin
      mem_q          <= ex_q;
      wb_q.valid     <= mem_q.valid;
      wb_q.dst       <= mem_q.dst;
      wb_q.reg_write <= mem_q.reg_write;
      if (issue) begin
        ex_q   <= id_tag;
        fwd1_q <= fwd1_d;
        fwd2_q <= fwd2_d;
      end else begin
        ex_q   <= '0;
        fwd1_q <= FWD_NONE;
        fwd2_q <= FWD_NONE;
      end
    end
  end

  assign fwd1_sel = fwd1_q;
  assign fwd2_sel = fwd2_q;
  assign ex_valid = ex_q.valid;

`ifdef HAZARD_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush && id_valid && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Self-checking bench for ex_hazard_controller: directed hazard scenarios
// plus randomized instruction streams against a producer-history model.
module tb_ex_hazard_controller;

  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_src1;
  logic          id_src1_used;
  logic [AW-1:0] id_src2;
  logic          id_src2_used;
  logic [AW-1:0] id_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic [1:0]    fwd1_sel;
  logic [1:0]    fwd2_sel;
  logic          stall;
  logic          ex_valid;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_hazard_controller #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src1_used(id_src1_used),
    .id_src2     (id_src2),
    .id_src2_used(id_src2_used),
    .id_dst      (id_dst),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .fwd1_sel    (fwd1_sel),
    .fwd2_sel    (fwd2_sel),
    .stall       (stall),
    .ex_valid    (ex_valid)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  task automatic drive(input logic v, input logic [AW-1:0] s1, input logic u1,
                       input logic [AW-1:0] s2, input logic u2, input logic [AW-1:0] d,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    n_cmp++; if (fwd1_sel !== 2'b00) begin n_bad++; $display("FAIL reset_fwd1 got %b want 00", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b00) begin n_bad++; $display("FAIL reset_fwd2 got %b want 00", fwd2_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
    n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL reset_flush_count got %0d want 0", flush_count); end
`endif
    rst = 1'b0;
    idle(2);
  endtask

  // ADD R1,R2,R3 ; ADD R2,R1,R3
  task automatic test_fwd_exmem();
    idle(2);
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL exmem_stall_a got %0b want 0", stall); end
    tick();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL exmem_stall_b got %0b want 0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL exmem_ex_valid got %0b want 1", ex_valid); end
    n_cmp++; if (fwd1_sel !== 2'b01) begin n_bad++; $display("FAIL exmem_fwd1 got %b want 01", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b00) begin n_bad++; $display("FAIL exmem_fwd2 got %b want 00", fwd2_sel); end
  endtask

  // ADD R1 ; NOP ; SUB R4,R1,R1
  task automatic test_fwd_memwb();
    idle(2);
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1, 1, 4, 1, 0, 0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL memwb_stall got %0b want 0", stall); end
    tick();
    n_cmp++; if (fwd1_sel !== 2'b10) begin n_bad++; $display("FAIL memwb_fwd1 got %b want 10", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b10) begin n_bad++; $display("FAIL memwb_fwd2 got %b want 10", fwd2_sel); end
  endtask

  // LDD R5 ; ADD R6,R5,R0
  task automatic test_load_use();
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] sc0;
`endif
    idle(2);
`ifdef HAZARD_PERF_EN
    sc0 = stall_count;
`endif
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %0b want 0", ex_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once got %0b want 0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_ex_valid got %0b want 1", ex_valid); end
    n_cmp++; if (fwd1_sel !== 2'b10) begin n_bad++; $display("FAIL lu_fwd1 got %b want 10", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b00) begin n_bad++; $display("FAIL lu_fwd2 got %b want 00", fwd2_sel); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (stall_count !== sc0 + 1'b1) begin n_bad++; $display("FAIL lu_stall_count got %0d want %0d", stall_count, sc0 + 1'b1); end
`endif
  endtask

  // ADD R1 ; ADD R1 ; OR R2,R1 (src2 names R1 but is unused)
  task automatic test_youngest();
    idle(2);
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    tick();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 1, 1, 0, 2, 1, 0, 0);
    tick();
    n_cmp++; if (fwd1_sel !== 2'b01) begin n_bad++; $display("FAIL young_fwd1 got %b want 01", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b00) begin n_bad++; $display("FAIL young_fwd2_unused got %b want 00", fwd2_sel); end
  endtask

  task automatic test_flush_stall();
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] sc0;
    logic [CW-1:0] fc0;
`endif
    idle(2);
`ifdef HAZARD_PERF_EN
    sc0 = stall_count;
    fc0 = flush_count;
`endif
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 1);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall got %0b want 0", stall); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_bubble got %0b want 0", ex_valid); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (flush_count !== fc0 + 1'b1) begin n_bad++; $display("FAIL fl_flush_count got %0d want %0d", flush_count, fc0 + 1'b1); end
    n_cmp++; if (stall_count !== sc0) begin n_bad++; $display("FAIL fl_stall_count got %0d want %0d", stall_count, sc0); end
`endif
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0);
    tick();
    n_cmp++; if (fwd1_sel !== 2'b10) begin n_bad++; $display("FAIL fl_after_fwd1 got %b want 10", fwd1_sel); end
  endtask

  task automatic test_rst_stall();
    idle(2);
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rs_pre_stall got %0b want 1", stall); end
    rst = 1'b1;
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rs_ex_valid got %0b want 0", ex_valid); end
    n_cmp++; if (fwd1_sel !== 2'b00) begin n_bad++; $display("FAIL rs_fwd1 got %b want 00", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'b00) begin n_bad++; $display("FAIL rs_fwd2 got %b want 00", fwd2_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rs_stall got %0b want 0", stall); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (stall_count !== '0) begin n_bad++; $display("FAIL rs_stall_count got %0d want 0", stall_count); end
    n_cmp++; if (flush_count !== '0) begin n_bad++; $display("FAIL rs_flush_count got %0d want 0", flush_count); end
`endif
    rst = 1'b0;
    idle(2);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_saturate();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 0, 1);
      tick();
    end
    n_cmp++; if (flush_count !== 4'd15) begin n_bad++; $display("FAIL sat_reach got %0d want 15", flush_count); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 0, 1);
      tick();
    end
    n_cmp++; if (flush_count !== 4'd15) begin n_bad++; $display("FAIL sat_hold got %0d want 15", flush_count); end
    idle(2);
  endtask
`endif

  // Reference model: history of what entered EX, youngest first.
  typedef struct {bit v; int dst; bit rw; bit mr;} ent_t;
  ent_t hist[$];

  function automatic int ref_sel(input int src, input bit used);
    if (!used) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].v && hist[k].rw && hist[k].dst == src) return (k == 0) ? 1 : 2;
    return 0;
  endfunction

  task automatic test_random();
    logic          r_v, r_u1, r_u2, r_rw, r_mr, r_fl;
    logic [AW-1:0] r_s1, r_s2, r_d;
    bit            held;
    bit            exp_st;
    int            ef1, ef2;
    int            mstall, mflush;
    ent_t          ne;
    ent_t          bub;
    bub = '{v:0, dst:0, rw:0, mr:0};
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    hist.delete();
    hist.push_back(bub);
    hist.push_back(bub);
    mstall = 0; mflush = 0; held = 0;
    {r_v, r_u1, r_u2, r_rw, r_mr, r_fl, r_s1, r_s2, r_d} = '0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        r_v  = ($urandom_range(0, 7) != 0);
        r_s1 = AW'($urandom_range(0, 3));
        r_s2 = AW'($urandom_range(0, 3));
        r_d  = AW'($urandom_range(0, 3));
        r_u1 = ($urandom_range(0, 4) != 0);
        r_u2 = ($urandom_range(0, 2) != 0);
        r_rw = ($urandom_range(0, 3) != 0);
        r_mr = ($urandom_range(0, 2) == 0);
        r_fl = ($urandom_range(0, 9) == 0);
      end
      drive(r_v, r_s1, r_u1, r_s2, r_u2, r_d, r_rw, r_mr, r_fl);
      exp_st = r_v && !r_fl && hist[0].v && hist[0].mr && hist[0].rw &&
               ((r_u1 && hist[0].dst == int'(r_s1)) || (r_u2 && hist[0].dst == int'(r_s2)));
      n_cmp++; if (stall !== exp_st) begin n_bad++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", c, stall, exp_st); end
      if (exp_st && mstall < 15) mstall++;
      if (r_fl && r_v && mflush < 15) mflush++;
      if (!r_v || r_fl || exp_st) begin
        ne = bub; ef1 = 0; ef2 = 0;
      end else begin
        ef1 = ref_sel(int'(r_s1), r_u1);
        ef2 = ref_sel(int'(r_s2), r_u2);
        ne = '{v:1, dst:int'(r_d), rw:r_rw, mr:r_mr};
      end
      hist.push_front(ne);
      void'(hist.pop_back());
      tick();
      n_cmp++; if (ex_valid !== ne.v) begin n_bad++; $display("FAIL rnd_ex_valid cyc %0d got %0b want %0b", c, ex_valid, ne.v); end
      n_cmp++; if (fwd1_sel !== 2'(ef1)) begin n_bad++; $display("FAIL rnd_fwd1 cyc %0d got %b want %0d", c, fwd1_sel, ef1); end
      n_cmp++; if (fwd2_sel !== 2'(ef2)) begin n_bad++; $display("FAIL rnd_fwd2 cyc %0d got %b want %0d", c, fwd2_sel, ef2); end
      held = exp_st;
    end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (stall_count !== CW'(mstall)) begin n_bad++; $display("FAIL rnd_stall_count got %0d want %0d", stall_count, mstall); end
    n_cmp++; if (flush_count !== CW'(mflush)) begin n_bad++; $display("FAIL rnd_flush_count got %0d want %0d", flush_count, mflush); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_src1 = '0; id_src1_used = 0; id_src2 = '0; id_src2_used = 0;
    id_dst = '0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_youngest();
    test_flush_stall();
    test_rst_stall();
`ifdef HAZARD_PERF_EN
    test_saturate();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
